// File: rtl/piso_tx_4bits_if.sv
// Parallel load handshake and serial output bundle for the 4-bit PISO transmitter.
// Handshake: a word is accepted on a rising clk edge where load=1 and ready=1.
interface piso_tx_4bits_if;
  logic [3:0] data;
  logic       load;
  logic       ready;
  logic       tx;
  logic       busy;
  logic       done;

  modport master (output data, output load, input ready, input tx, input busy, input done);
  modport slave  (input data, input load, output ready, output tx, output busy, output done);
endinterface

// File: rtl/piso_tx_4bits.sv
// Framed PISO transmitter: start bit, 4 data bits LSB first, stop bit, each
// CLKS_PER_BIT clocks long; all outputs come straight from flops.
module piso_tx_4bits #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  piso_tx_4bits_if.slave       bus,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [7:0] BAUD_LAST = 8'(CLKS_PER_BIT - 1);

  state_t     state_q, state_d;
  logic [7:0] baud_q, baud_d;
  logic [1:0] bit_q, bit_d;
  logic [3:0] shreg_q, shreg_d;
  logic       tx_q, tx_d;
  logic       ready_q, ready_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       bit_end;

  assign bit_end = (baud_q == BAUD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    done_d  = 1'b0;
    tx_d    = 1'b1;
    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (bus.load && ready_q) begin
          shreg_d = bus.data;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 8'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_d  = '0;
          shreg_d = {1'b0, shreg_q[3:1]};
          bit_d   = bit_q + 2'd1;
          if (bit_q == 2'd3) state_d = STOP;
        end else begin
          baud_d = baud_q + 8'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          baud_d = baud_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so the flops line up with state_q.
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      default: tx_d = 1'b1;
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  assign bus.tx    = tx_q;
  assign bus.ready = ready_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign state_dbg = state_q;

endmodule
